dec8b10b_lanes: RTL and testbench
=================================

Name: dec8b10b_lanes

Overview:
- Parametrised, registered multi-lane 8b/10b decoder; successor to the single-symbol combinational decode path.
- Decodes LANES 10b code-groups per cycle and chains running disparity lane-to-lane within the cycle, then across cycles.
- Flags code and disparity errors per lane and runs a comma-based word-sync state machine.
- Sits between the deserialiser and the link layer.

Parameters:
LANES, 2, code-groups per word; lane 0 is earliest in time.
SYNC_COMMAS, 3, consecutive error-free comma words needed to acquire sync.
ERR_THRESH, 4, bad-word credit that drops sync.
GOOD_RUN, 4, consecutive good words that repay one bad-word credit.
CNT_W, 16, error counter width.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  in_data valid this cycle.
in_data  input  10*LANES  lane n at [10n+9:10n], bit order {a,b,c,d,e,i,f,g,h,j}, a at MSB.
out_valid  output  1  registered in_valid.
out_data  output  8*LANES  lane n at [8n+7:8n] as {H,G,F,E,D,C,B,A}.
out_k  output  LANES  lane is a valid K code.
code_err  output  LANES  lane is not a legal code-group.
disp_err  output  LANES  lane violates running disparity.
rd_out  output  1  current running disparity; 1 = positive.
sync  output  1  FSM is in SYNC.
err_cnt  output  CNT_W  saturating error count.
err_cnt_clr  input  1  synchronous clear of err_cnt.

Behaviour:
- Reset values: all outputs 0; rd register 0 (negative); FSM in LOS; internal counters 0.
- Latency:
  - out_* registered 1 cycle after in_valid.
  - sync updates the cycle after the corresponding out_valid.
  - No backpressure. When in_valid=0: out_valid=0, out_data/out_k/err hold, rd register holds.
- Disparity chain:
  - Lane 0 uses the rd register. Lane n uses lane n-1's rd result.
  - rd register takes the last lane's result when in_valid=1.
  - The rd result is always computed from sub-block disparity (6b, then 4b), even on error.
  - Neutral sub-blocks keep rd. ±2 sub-blocks flip rd.
- Error rules:
  - disp_err: sub-block disparity +2 with entry rd positive, or -2 with entry rd negative.
  - code_err:
    - 6b or 4b disparity magnitude ≥4;
    - run length ≥5 across the 6b/4b boundary;
    - K-like patterns that are not legal K codes;
    - total disparity of ±4.
  - On code_err, out_data is don't-care and out_k=0.
- Comma: K28.5 (0x0FA RD-, 0x305 RD+). A word is a "comma word" if any lane decodes to K28.5 without error. A word is "bad" if any lane has code_err or disp_err.
- Sync FSM, evaluated only on out_valid words:
  - LOS → ACQ on a good comma word; comma_cnt=1.
  - ACQ:
    - bad word → LOS.
    - good comma word → comma_cnt+1.
    - comma_cnt reaching SYNC_COMMAS → SYNC; bad_cnt=0, good_cnt=0.
    - good non-comma words are ignored.
  - SYNC:
    - bad word → bad_cnt+1, good_cnt=0.
    - good word with bad_cnt>0 → good_cnt+1; on reaching GOOD_RUN, bad_cnt-1 and good_cnt=0.
    - bad_cnt reaching ERR_THRESH → LOS.
- Reset mid-word: everything returns to reset values immediately; the first post-reset word decodes with rd negative.

Optional Feature:
- DEC8B10B_ERR_CNT_EN defined:
  - On each out_valid word, err_cnt adds popcount(code_err|disp_err).
  - Saturates at all-ones.
  - err_cnt_clr wins over an increment in the same cycle; that cycle's errors are dropped.
- Undefined: err_cnt tied to 0, err_cnt_clr ignored, no counter flops.

Decomposition:
- Package dec8b10b_pkg holds:
  - sync state enum {LOS, ACQ, SYNC};
  - constants K28_5_RDN=10'h0FA, K28_5_RDP=10'h305, K28_5_DEC=8'hBC;
  - lane struct {data, k, code_err, disp_err}.
- One combinational sub-module, dec8b10b_sym: 10b + rd_in → data, k, code_err, disp_err, rd_next.
- It is instantiated LANES times in a generate chain.

Test Plan:
- Reset low mid-stream → all outputs 0 immediately. Release, in_data lane0=0x274 (D0.0 RD-), lane1=0x2AA (D21.5), in_valid=1 → next cycle out_data=0xB500, out_k=00, errs=0, rd_out=0.
- Lane0=0x0FA, lane1=0x2AA → out_k=01, out_data[7:0]=0xBC, rd_out=1. The next word with lane0=0x0FA → disp_err[0]=1.
- Lane1=0x3FF → code_err[1]=1, out_k[1]=0. With DEC8B10B_ERR_CNT_EN, err_cnt increments by 1.
- Three good comma words (0x0FA lane0, then 0x305 lane0 with matching rd) → sync=1 the cycle after the third out_valid. A bad word during ACQ → back to LOS.
- In SYNC: four bad words → sync=0. Alternatively, bad, 4 good, bad, 4 good, bad, bad → sync stays 1 (bad_cnt peaks at 2).
- err_cnt at 16'hFFFF plus an error word → stays 16'hFFFF. err_cnt_clr plus an error in the same cycle → 0.

Source files
------------

// File: rtl/dec8b10b_pkg.sv
// Shared types, constants and sub-block decode tables for the multi-lane 8b/10b decoder.
package dec8b10b_pkg;

  typedef enum logic [1:0] {
    LOS  = 2'd0,
    ACQ  = 2'd1,
    SYNC = 2'd2
  } sync_state_e;

  localparam logic [9:0] K28_5_RDN = 10'h0FA;
  localparam logic [9:0] K28_5_RDP = 10'h305;
  localparam logic [7:0] K28_5_DEC = 8'hBC;

  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic       code_err;
    logic       disp_err;
  } lane_t;

  // abcdei -> {valid, is_k28, EDCBA}
  function automatic logic [6:0] dec6(input logic [5:0] s);
    logic [6:0] r;
    case (s)
      6'b100111, 6'b011000: r = {2'b10, 5'd0};
      6'b011101, 6'b100010: r = {2'b10, 5'd1};
      6'b101101, 6'b010010: r = {2'b10, 5'd2};
      6'b110001:            r = {2'b10, 5'd3};
      6'b110101, 6'b001010: r = {2'b10, 5'd4};
      6'b101001:            r = {2'b10, 5'd5};
      6'b011001:            r = {2'b10, 5'd6};
      6'b111000, 6'b000111: r = {2'b10, 5'd7};
      6'b111001, 6'b000110: r = {2'b10, 5'd8};
      6'b100101:            r = {2'b10, 5'd9};
      6'b010101:            r = {2'b10, 5'd10};
      6'b110100:            r = {2'b10, 5'd11};
      6'b001101:            r = {2'b10, 5'd12};
      6'b101100:            r = {2'b10, 5'd13};
      6'b011100:            r = {2'b10, 5'd14};
      6'b010111, 6'b101000: r = {2'b10, 5'd15};
      6'b011011, 6'b100100: r = {2'b10, 5'd16};
      6'b100011:            r = {2'b10, 5'd17};
      6'b010011:            r = {2'b10, 5'd18};
      6'b110010:            r = {2'b10, 5'd19};
      6'b001011:            r = {2'b10, 5'd20};
      6'b101010:            r = {2'b10, 5'd21};
      6'b011010:            r = {2'b10, 5'd22};
      6'b111010, 6'b000101: r = {2'b10, 5'd23};
      6'b110011, 6'b001100: r = {2'b10, 5'd24};
      6'b100110:            r = {2'b10, 5'd25};
      6'b010110:            r = {2'b10, 5'd26};
      6'b110110, 6'b001001: r = {2'b10, 5'd27};
      6'b001110:            r = {2'b10, 5'd28};
      6'b101110, 6'b010001: r = {2'b10, 5'd29};
      6'b011110, 6'b100001: r = {2'b10, 5'd30};
      6'b101011, 6'b010100: r = {2'b10, 5'd31};
      6'b001111, 6'b110000: r = {2'b11, 5'd28};
      default:              r = 7'd0;
    endcase
    return r;
  endfunction

  // fghj -> {valid, HGF}
  function automatic logic [3:0] dec4(input logic [3:0] f);
    logic [3:0] r;
    case (f)
      4'b1011, 4'b0100:                   r = {1'b1, 3'd0};
      4'b1001:                            r = {1'b1, 3'd1};
      4'b0101:                            r = {1'b1, 3'd2};
      4'b1100, 4'b0011:                   r = {1'b1, 3'd3};
      4'b1101, 4'b0010:                   r = {1'b1, 3'd4};
      4'b1010:                            r = {1'b1, 3'd5};
      4'b0110:                            r = {1'b1, 3'd6};
      4'b1110, 4'b0001, 4'b0111, 4'b1000: r = {1'b1, 3'd7};
      default:                            r = 4'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dec8b10b_lanes_sym.sv
// Combinational single code-group decoder: 10b + entry disparity -> byte, K flag, errors, exit disparity.
module dec8b10b_sym
  import dec8b10b_pkg::*;
(
  input  logic [9:0] code_i,
  input  logic       rd_i,
  output lane_t      lane_o,
  output logic       rd_o
);

  logic [5:0] six;
  logic [3:0] four, four_eff;
  logic [6:0] d6;
  logic [3:0] d4;
  logic [2:0] ones6, ones4;
  logic [3:0] ones10;
  logic       k28, k28_ok, a7_form, k_alt, a7_data, run5;
  logic       r6p, r6n, r4p, r4n, rd6, cerr;

  always_comb begin
    six      = code_i[9:4];
    four     = code_i[3:0];
    d6       = dec6(six);
    k28      = d6[5];
    // K28 with the RD+ 6b block carries its 4b block complemented
    four_eff = (k28 && six == 6'b110000) ? ~four : four;
    d4       = dec4(four_eff);

    ones6  = '0;
    ones4  = '0;
    ones10 = '0;
    for (int i = 0; i < 6; i++) ones6 = ones6 + 3'(six[i]);
    for (int i = 0; i < 4; i++) ones4 = ones4 + 3'(four[i]);
    for (int i = 0; i < 10; i++) ones10 = ones10 + 4'(code_i[i]);

    run5 = 1'b0;
    for (int i = 0; i <= 5; i++)
      if (code_i[i +: 5] == 5'b11111 || code_i[i +: 5] == 5'b00000) run5 = 1'b1;

    k28_ok = four_eff inside {4'b0100, 4'b1001, 4'b0101, 4'b0011,
                              4'b0010, 4'b1010, 4'b0110, 4'b1000};
    a7_form = (four == 4'b1000) || (four == 4'b0111);
    k_alt   = (four == 4'b1000 && six inside {6'b111010, 6'b110110, 6'b101110, 6'b011110}) ||
              (four == 4'b0111 && six inside {6'b000101, 6'b001001, 6'b010001, 6'b100001});
    a7_data = (four == 4'b1000 && six inside {6'b110100, 6'b101100, 6'b011100}) ||
              (four == 4'b0111 && six inside {6'b100011, 6'b010011, 6'b001011});

    // unlisted 6b blocks and 0000/1111 also cover the magnitude >= 4 cases
    cerr = !d6[6] || !d4[3] || (ones10 < 4'd4) || (ones10 > 4'd6) ||
           (k28 ? !k28_ok : ((a7_form && !k_alt && !a7_data) || run5));

    r6p  = (ones6 == 3'd4);
    r6n  = (ones6 == 3'd2);
    rd6  = (r6p || r6n) ? !rd_i : rd_i;
    r4p  = (ones4 == 3'd3);
    r4n  = (ones4 == 3'd1);
    rd_o = (r4p || r4n) ? !rd6 : rd6;

    lane_o.data     = {d4[2:0], d6[4:0]};
    lane_o.k        = (k28 || k_alt) && !cerr;
    lane_o.code_err = cerr;
    lane_o.disp_err = (r6p && rd_i) || (r6n && !rd_i) || (r4p && rd6) || (r4n && !rd6);
  end

endmodule

// File: rtl/dec8b10b_lanes.sv
// Registered LANES-wide 8b/10b decoder with chained disparity and comma word-sync.
// Optional saturating error counter enabled by DEC8B10B_ERR_CNT_EN.
//   state | meaning
//   LOS   | no alignment, waiting for a good comma word
//   ACQ   | counting consecutive good comma words
//   SYNC  | aligned; bad words drain a credit repaid by good runs
module dec8b10b_lanes
  import dec8b10b_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int SYNC_COMMAS = 3,
  parameter int ERR_THRESH  = 4,
  parameter int GOOD_RUN    = 4,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [10*LANES-1:0]  in_data,
  output logic                 out_valid,
  output logic [8*LANES-1:0]   out_data,
  output logic [LANES-1:0]     out_k,
  output logic [LANES-1:0]     code_err,
  output logic [LANES-1:0]     disp_err,
  output logic                 rd_out,
  output logic                 sync,
  output logic [CNT_W-1:0]     err_cnt,
  input  logic                 err_cnt_clr
);

  localparam int CC_W = $clog2(SYNC_COMMAS + 1);
  localparam int BC_W = $clog2(ERR_THRESH + 1);
  localparam int GC_W = $clog2(GOOD_RUN + 1);
  localparam logic [CC_W-1:0] CC_TGT = CC_W'(SYNC_COMMAS);
  localparam logic [BC_W-1:0] BC_TGT = BC_W'(ERR_THRESH);
  localparam logic [GC_W-1:0] GC_TGT = GC_W'(GOOD_RUN);

  logic [LANES:0]         rd_chain;
  lane_t                  lane_d [LANES];
  logic                   rd_q, out_valid_q;
  logic [8*LANES-1:0]     out_data_q;
  logic [LANES-1:0]       out_k_q, code_err_q, disp_err_q, lane_bad;
  logic                   word_comma, word_bad, good_comma;
  sync_state_e            state_q;
  logic                   sync_q;
  logic [CC_W-1:0]        comma_cnt_q, comma_inc;
  logic [BC_W-1:0]        bad_cnt_q, bad_inc;
  logic [GC_W-1:0]        good_cnt_q, good_inc;

  assign rd_chain[0] = rd_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dec8b10b_sym u_sym (
      .code_i (in_data[10*g +: 10]),
      .rd_i   (rd_chain[g]),
      .lane_o (lane_d[g]),
      .rd_o   (rd_chain[g+1])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      rd_q        <= 1'b0;
      out_data_q  <= '0;
      out_k_q     <= '0;
      code_err_q  <= '0;
      disp_err_q  <= '0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        rd_q <= rd_chain[LANES];
        for (int n = 0; n < LANES; n++) begin
          out_data_q[8*n +: 8] <= lane_d[n].data;
          out_k_q[n]           <= lane_d[n].k;
          code_err_q[n]        <= lane_d[n].code_err;
          disp_err_q[n]        <= lane_d[n].disp_err;
        end
      end
    end
  end

  always_comb begin
    word_comma = 1'b0;
    for (int n = 0; n < LANES; n++)
      if (out_k_q[n] && out_data_q[8*n +: 8] == K28_5_DEC && !code_err_q[n] && !disp_err_q[n])
        word_comma = 1'b1;
  end

  assign lane_bad   = code_err_q | disp_err_q;
  assign word_bad   = |lane_bad;
  assign good_comma = word_comma && !word_bad;
  assign comma_inc  = comma_cnt_q + CC_W'(1);
  assign bad_inc    = bad_cnt_q + BC_W'(1);
  assign good_inc   = good_cnt_q + GC_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOS;
      sync_q      <= 1'b0;
      comma_cnt_q <= '0;
      bad_cnt_q   <= '0;
      good_cnt_q  <= '0;
    end else if (out_valid_q) begin
      case (state_q)
        LOS: if (good_comma) begin
          comma_cnt_q <= CC_W'(1);
          bad_cnt_q   <= '0;
          good_cnt_q  <= '0;
          if (CC_TGT <= CC_W'(1)) begin
            state_q <= SYNC;
            sync_q  <= 1'b1;
          end else begin
            state_q <= ACQ;
          end
        end
        ACQ: if (word_bad) begin
          state_q     <= LOS;
          comma_cnt_q <= '0;
        end else if (word_comma) begin
          comma_cnt_q <= comma_inc;
          if (comma_inc == CC_TGT) begin
            state_q    <= SYNC;
            sync_q     <= 1'b1;
            bad_cnt_q  <= '0;
            good_cnt_q <= '0;
          end
        end
        SYNC: if (word_bad) begin
          good_cnt_q <= '0;
          if (bad_inc == BC_TGT) begin
            state_q     <= LOS;
            sync_q      <= 1'b0;
            bad_cnt_q   <= '0;
            comma_cnt_q <= '0;
          end else begin
            bad_cnt_q <= bad_inc;
          end
        end else if (bad_cnt_q != '0) begin
          if (good_inc == GC_TGT) begin
            bad_cnt_q  <= bad_cnt_q - BC_W'(1);
            good_cnt_q <= '0;
          end else begin
            good_cnt_q <= good_inc;
          end
        end
        default: begin
          state_q <= LOS;
          sync_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEC8B10B_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, err_pop;
  logic [CNT_W:0]   err_sum;

  always_comb begin
    err_pop = '0;
    for (int n = 0; n < LANES; n++) err_pop = err_pop + CNT_W'(lane_bad[n]);
    err_sum   = {1'b0, err_cnt_q} + {1'b0, err_pop};
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr)      err_cnt_d = '0;
    else if (out_valid_q) err_cnt_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = err_cnt_clr;
  assign err_cnt    = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_k     = out_k_q;
  assign code_err  = code_err_q;
  assign disp_err  = disp_err_q;
  assign rd_out    = rd_q;
  assign sync      = sync_q;

endmodule

// File: tb/tb_dec8b10b_lanes.sv
// Directed bench for dec8b10b_lanes (2 lanes): decode, disparity, errors, word-sync, error counter.
module tb_dec8b10b_lanes;
  import dec8b10b_pkg::*;

  localparam logic [9:0] D0_0 = 10'h274;
  localparam logic [9:0] D21_5 = 10'h2AA;
  localparam logic [9:0] BADC = 10'h3FF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] in_data = '0;
  logic        err_cnt_clr = 1'b0;
  logic        out_valid, rd_out, sync;
  logic [15:0] out_data, err_cnt;
  logic [1:0]  out_k, code_err, disp_err;

  int n_chk = 0;
  int n_pass = 0;

  dec8b10b_lanes dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_k(out_k),
    .code_err(code_err), .disp_err(disp_err), .rd_out(rd_out),
    .sync(sync), .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [9:0] l0, input logic [9:0] l1, input logic v);
    @(negedge clk);
    in_data  = {l1, l0};
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    send(10'h000, 10'h000, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic acquire();
    send(K28_5_RDN, D21_5, 1'b1);
    send(K28_5_RDP, D21_5, 1'b1);
    send(K28_5_RDN, D21_5, 1'b1);
    idle();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // asynchronous reset mid-stream
    send(K28_5_RDN, D21_5, 1'b1);
    #2;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_k", out_k, 0);
    check("rst_rd_out", rd_out, 0);
    check("rst_sync", sync, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    reset = 1'b1;

    // basic decode, first word after reset uses RD-
    send(D0_0, D21_5, 1'b1);
    check("d0_out_valid", out_valid, 1);
    check("d0_out_data", out_data, 16'hB500);
    check("d0_out_k", out_k, 2'b00);
    check("d0_code_err", code_err, 2'b00);
    check("d0_disp_err", disp_err, 2'b00);
    check("d0_rd_out", rd_out, 0);
    send(K28_5_RDN, K28_5_RDN, 1'b0);
    check("idle_out_valid", out_valid, 0);
    check("idle_hold_data", out_data, 16'hB500);
    check("idle_hold_rd", rd_out, 0);

    send(K28_5_RDN, D21_5, 1'b1);
    check("k285_out_data", out_data, 16'hB5BC);
    check("k285_out_k", out_k, 2'b01);
    check("k285_errs", {code_err, disp_err}, 4'b0000);
    check("k285_rd_out", rd_out, 1);
    send(K28_5_RDN, D21_5, 1'b1);
    check("rdn_at_pos_disp_err", disp_err, 2'b01);
    check("rdn_at_pos_code_err", code_err, 2'b00);

    // code errors
    do_reset();
    send(D0_0, BADC, 1'b1);
    check("allones_code_err", code_err, 2'b10);
    check("allones_out_k", out_k, 2'b00);
    check("allones_disp_err", disp_err, 2'b00);
    send(10'h0F1, D21_5, 1'b1);
    check("bad_k28_code_err", code_err, 2'b01);
    check("bad_k28_out_k", out_k, 2'b00);
    check("bad_k28_disp_err", disp_err, 2'b00);
    send(10'h27B, D21_5, 1'b1);
    check("disp4_code_err", code_err, 2'b01);
    check("disp4_disp_err", disp_err, 2'b01);
    send(10'h23E, D21_5, 1'b1);
    check("run5_code_err", code_err, 2'b01);
    check("run5_out_k", out_k, 2'b00);
    idle();
    idle();
`ifdef DEC8B10B_ERR_CNT_EN
    check("err_cnt_accum", err_cnt, 4);
    err_cnt_clr = 1'b1;
    send(BADC, BADC, 1'b1);
    idle();
    err_cnt_clr = 1'b0;
    idle();
    check("err_cnt_clr_wins", err_cnt, 0);
    send(BADC, BADC, 1'b1);
    idle();
    idle();
    check("err_cnt_two", err_cnt, 2);
`else
    check("err_cnt_tied", err_cnt, 0);
`endif

    // acquisition and loss after four bad words
    do_reset();
    send(K28_5_RDN, D21_5, 1'b1);
    send(K28_5_RDP, D21_5, 1'b1);
    check("k285p_out_data", out_data[7:0], 8'hBC);
    check("k285p_out_k", out_k, 2'b01);
    check("k285p_errs", {code_err, disp_err}, 4'b0000);
    send(K28_5_RDN, D21_5, 1'b1);
    check("acq_two_commas", sync, 0);
    idle();
    check("sync_acquired", sync, 1);
    repeat (4) send(BADC, D21_5, 1'b1);
    check("sync_after_3_bad", sync, 1);
    idle();
    check("sync_lost_4_bad", sync, 0);

    // bad word during ACQ restarts the comma count
    do_reset();
    send(K28_5_RDN, D21_5, 1'b1);
    send(BADC, BADC, 1'b1);
    send(K28_5_RDP, D21_5, 1'b1);
    send(K28_5_RDN, D21_5, 1'b1);
    idle();
    check("acq_bad_restart", sync, 0);
    send(K28_5_RDP, D21_5, 1'b1);
    idle();
    check("acq_reacquire", sync, 1);

    // good runs repay bad-word credit
    do_reset();
    acquire();
    check("leak_start_sync", sync, 1);
    send(BADC, D21_5, 1'b1);
    repeat (4) send(D21_5, D21_5, 1'b1);
    send(BADC, D21_5, 1'b1);
    repeat (4) send(D21_5, D21_5, 1'b1);
    send(BADC, D21_5, 1'b1);
    send(BADC, D21_5, 1'b1);
    idle();
    check("leak_keeps_sync", sync, 1);
    send(BADC, D21_5, 1'b1);
    send(BADC, D21_5, 1'b1);
    idle();
    check("leak_then_lost", sync, 0);

`ifdef DEC8B10B_ERR_CNT_EN
    // saturation
    do_reset();
    @(negedge clk);
    in_data  = {BADC, BADC};
    in_valid = 1'b1;
    repeat (32767) @(posedge clk);
    @(negedge clk);
    in_data = {D21_5, BADC};
    @(posedge clk);
    #1;
    idle();
    idle();
    check("err_cnt_full", err_cnt, 16'hFFFF);
    send(BADC, BADC, 1'b1);
    idle();
    idle();
    check("err_cnt_saturate", err_cnt, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
